// File: rtl/pwm_gate_monitor_pkg.sv
// Shared definitions for the flying-capacitor gate-bus monitor.
package pwm_gate_monitor_pkg;

    // Per-pair checker state
    typedef enum logic [2:0] {
        PAIR_UNKNOWN = 3'd0,
        PAIR_P_ON    = 3'd1,
        PAIR_N_ON    = 3'd2,
        PAIR_GAP     = 3'd3,
        PAIR_BOTH_ON = 3'd4
    } pair_state_e;

    // Period measurement FSM encoding
    localparam logic [0:0] MEAS_WAIT_SYNC = 1'b0;
    localparam logic [0:0] MEAS_MEASURE   = 1'b1;

    // Fault flag bit positions
    localparam int unsigned FltShootA  = 0;
    localparam int unsigned FltShootB  = 1;
    localparam int unsigned FltDeadA   = 2;
    localparam int unsigned FltDeadB   = 3;
    localparam int unsigned FltTimeout = 4;
    localparam int unsigned NumFlags   = 5;

    // Gate bus lane positions and polarities
    localparam int unsigned GateP1 = 0;
    localparam int unsigned GateP2 = 1;
    localparam int unsigned GateN1 = 2;
    localparam int unsigned GateN2 = 3;
    localparam logic PmosOnLevel = 1'b0;
    localparam logic NmosOnLevel = 1'b1;

    // Bus value with every device off
    localparam logic [3:0] GateIdle = {~NmosOnLevel, ~NmosOnLevel, ~PmosOnLevel, ~PmosOnLevel};

endpackage

// File: rtl/pwm_gate_monitor_pair_checker.sv
// Shoot-through and dead-time checker for one complementary gate pair.
module gate_pair_checker
    import pwm_gate_monitor_pkg::*;
#(
    parameter int unsigned MinDeadTime = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic p_on_i,
    input  logic n_on_i,
    output logic shoot_o,
    output logic dead_o
);

    localparam int unsigned GapW = (MinDeadTime < 2) ? 1 : $clog2(MinDeadTime + 1);
    localparam logic [GapW-1:0] GapMin = GapW'(MinDeadTime);

    pair_state_e     state_q, state_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    // Set when the current gap was entered from a single-on state
    logic            armed_q, armed_d;

    // Next-state, gap counting and violation pulses
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        armed_d   = armed_q;
        shoot_o   = 1'b0;
        dead_o    = 1'b0;
        case ({p_on_i, n_on_i})
            2'b11: begin
                state_d = PAIR_BOTH_ON;
                shoot_o = 1'b1;
            end
            2'b00: begin
                state_d = PAIR_GAP;
                if (state_q == PAIR_GAP) begin
                    if (gap_cnt_q < GapMin) begin
                        gap_cnt_d = gap_cnt_q + GapW'(1);
                    end
                end else begin
                    gap_cnt_d = GapW'(1);
                    armed_d   = (state_q == PAIR_P_ON) || (state_q == PAIR_N_ON);
                end
            end
            2'b10: begin
                state_d = PAIR_P_ON;
                dead_o  = (state_q == PAIR_N_ON) ||
                          ((state_q == PAIR_GAP) && armed_q && (gap_cnt_q < GapMin));
            end
            2'b01: begin
                state_d = PAIR_N_ON;
                dead_o  = (state_q == PAIR_P_ON) ||
                          ((state_q == PAIR_GAP) && armed_q && (gap_cnt_q < GapMin));
            end
            default: ;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= PAIR_UNKNOWN;
            gap_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            armed_q   <= armed_d;
        end
    end

endmodule

// File: rtl/pwm_gate_monitor.sv
// Receive-side monitor of the 3-level gate bus: period/duty measurement
// plus shoot-through, dead-time and sync-timeout fault latching.
module pwm_gate_monitor
    import pwm_gate_monitor_pkg::*;
#(
    parameter int unsigned CountWidth  = 8,
    parameter int unsigned MinDeadTime = 2,
    parameter int unsigned MaxPeriod   = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            pwm_i,
    input  logic                  sync_i,
    input  logic                  clear_i,
    output logic [CountWidth-1:0] duty_d1_o,
    output logic [CountWidth-1:0] duty_d2_o,
    output logic [CountWidth-1:0] period_o,
    output logic                  valid_o,
    output logic [NumFlags-1:0]   fault_flags_o,
    output logic                  trip_o
);

    localparam logic [CountWidth-1:0] CntMax     = '1;
    localparam logic [CountWidth-1:0] CntTimeout = CountWidth'(MaxPeriod);
    localparam logic [CountWidth-1:0] CntOne     = CountWidth'(1);

    logic [3:0]            pwm_q, pwm_d;
    logic                  sync_q, sync_d;
    logic [0:0]            meas_q, meas_d;
    logic [CountWidth-1:0] period_cnt_q, period_cnt_d;
    logic [CountWidth-1:0] on1_cnt_q, on1_cnt_d;
    logic [CountWidth-1:0] on2_cnt_q, on2_cnt_d;
    logic [CountWidth-1:0] duty1_q, duty1_d;
    logic [CountWidth-1:0] duty2_q, duty2_d;
    logic [CountWidth-1:0] period_q, period_d;
    logic                  valid_q, valid_d;
    logic [NumFlags-1:0]   flags_q, flags_d;
    logic                  trip_q, trip_d;

    logic p1_on, p2_on, n1_on, n2_on;
    logic shoot_a, shoot_b, dead_a, dead_b, timeout;
    logic [NumFlags-1:0] flag_set;

    function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v,
                                                      input logic en);
        if (en && (v != CntMax)) return v + CntOne;
        return v;
    endfunction

    // Device on-state decode from the registered bus
    always_comb begin
        p1_on = (pwm_q[GateP1] == PmosOnLevel);
        p2_on = (pwm_q[GateP2] == PmosOnLevel);
        n1_on = (pwm_q[GateN1] == NmosOnLevel);
        n2_on = (pwm_q[GateN2] == NmosOnLevel);
    end

    gate_pair_checker #(.MinDeadTime(MinDeadTime)) u_pair_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .p_on_i  (p1_on),
        .n_on_i  (n2_on),
        .shoot_o (shoot_a),
        .dead_o  (dead_a)
    );

    gate_pair_checker #(.MinDeadTime(MinDeadTime)) u_pair_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .p_on_i  (p2_on),
        .n_on_i  (n1_on),
        .shoot_o (shoot_b),
        .dead_o  (dead_b)
    );

    // Period/duty measurement; the window includes its own sync cycle
    always_comb begin
        pwm_d        = pwm_i;
        sync_d       = sync_i;
        meas_d       = meas_q;
        period_cnt_d = period_cnt_q;
        on1_cnt_d    = on1_cnt_q;
        on2_cnt_d    = on2_cnt_q;
        duty1_d      = duty1_q;
        duty2_d      = duty2_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        timeout      = 1'b0;
        case (meas_q)
            MEAS_WAIT_SYNC: begin
                period_cnt_d = '0;
                on1_cnt_d    = '0;
                on2_cnt_d    = '0;
                if (sync_q) begin
                    meas_d       = MEAS_MEASURE;
                    period_cnt_d = CntOne;
                    on1_cnt_d    = {{(CountWidth-1){1'b0}}, p1_on};
                    on2_cnt_d    = {{(CountWidth-1){1'b0}}, p2_on};
                end
            end
            default: begin
                if (sync_q) begin
                    duty1_d      = on1_cnt_q;
                    duty2_d      = on2_cnt_q;
                    period_d     = period_cnt_q;
                    valid_d      = 1'b1;
                    period_cnt_d = CntOne;
                    on1_cnt_d    = {{(CountWidth-1){1'b0}}, p1_on};
                    on2_cnt_d    = {{(CountWidth-1){1'b0}}, p2_on};
                end else if (period_cnt_q >= CntTimeout) begin
                    timeout      = 1'b1;
                    meas_d       = MEAS_WAIT_SYNC;
                    period_cnt_d = '0;
                    on1_cnt_d    = '0;
                    on2_cnt_d    = '0;
                end else begin
                    period_cnt_d = sat_inc(period_cnt_q, 1'b1);
                    on1_cnt_d    = sat_inc(on1_cnt_q, p1_on);
                    on2_cnt_d    = sat_inc(on2_cnt_q, p2_on);
                end
            end
        endcase
    end

    // Sticky fault flags; a new fault in the clear cycle survives the clear
    always_comb begin
        flag_set             = '0;
        flag_set[FltShootA]  = shoot_a;
        flag_set[FltShootB]  = shoot_b;
        flag_set[FltDeadA]   = dead_a;
        flag_set[FltDeadB]   = dead_b;
        flag_set[FltTimeout] = timeout;
        flags_d = (clear_i ? '0 : flags_q) | flag_set;
        trip_d  = |flags_q;
    end

    // All monitor state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_q        <= GateIdle;
            sync_q       <= 1'b0;
            meas_q       <= MEAS_WAIT_SYNC;
            period_cnt_q <= '0;
            on1_cnt_q    <= '0;
            on2_cnt_q    <= '0;
            duty1_q      <= '0;
            duty2_q      <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            flags_q      <= '0;
            trip_q       <= 1'b0;
        end else begin
            pwm_q        <= pwm_d;
            sync_q       <= sync_d;
            meas_q       <= meas_d;
            period_cnt_q <= period_cnt_d;
            on1_cnt_q    <= on1_cnt_d;
            on2_cnt_q    <= on2_cnt_d;
            duty1_q      <= duty1_d;
            duty2_q      <= duty2_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            flags_q      <= flags_d;
            trip_q       <= trip_d;
        end
    end

    assign duty_d1_o     = duty1_q;
    assign duty_d2_o     = duty2_q;
    assign period_o      = period_q;
    assign valid_o       = valid_q;
    assign fault_flags_o = flags_q;
    assign trip_o        = trip_q;

endmodule

// File: tb/tb_pwm_gate_monitor.sv
// Bench for pwm_gate_monitor: directed fault scenarios plus randomized
// periods, checked against a cycle-history reference model.
module tb_pwm_gate_monitor;

    localparam int unsigned CW   = 8;
    localparam int unsigned MDT  = 2;
    localparam int          MAXP = 255;
    localparam int          HIST = 32768;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [3:0]    pwm_i;
    logic          sync_i;
    logic          clear_i;
    logic [CW-1:0] duty_d1_o, duty_d2_o, period_o;
    logic          valid_o;
    logic [4:0]    fault_flags_o;
    logic          trip_o;

    pwm_gate_monitor #(.CountWidth(CW), .MinDeadTime(MDT), .MaxPeriod(MAXP)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pwm_i         (pwm_i),
        .sync_i        (sync_i),
        .clear_i       (clear_i),
        .duty_d1_o     (duty_d1_o),
        .duty_d2_o     (duty_d2_o),
        .period_o      (period_o),
        .valid_o       (valid_o),
        .fault_flags_o (fault_flags_o),
        .trip_o        (trip_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: per-cycle PMOS history and last accepted sync
    bit h_p1 [HIST];
    bit h_p2 [HIST];
    int cyc       = 0;
    int last_sync = -1;
    bit v_pipe    = 1'b0;
    int pv_d1 = 0, pv_d2 = 0, pv_p = 0;
    int exp_d1 = 0, exp_d2 = 0, exp_p = 0;

    // Current period waveform description
    int cfg_P, cfg_D1, cfg_D2, cfg_ga1, cfg_ga2, cfg_gb1, cfg_gb2;
    int ov_from = -1, ov_to = -1, clr_pos = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int count_on(input bit sel, input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) c += sel ? int'(h_p2[i % HIST]) : int'(h_p1[i % HIST]);
        return c;
    endfunction

    // {p_on, n_on} at position pos of a period: P on, gap, N on, gap
    function automatic bit [1:0] pat(input int pos, input int P, input int D,
                                     input int g1, input int g2);
        if (pos < D)      return 2'b10;
        if (pos < D + g1) return 2'b00;
        if (pos < P - g2) return 2'b01;
        return 2'b00;
    endfunction

    // One clock of stimulus; outputs checked against the model each cycle
    task automatic step(input bit p1, input bit p2, input bit n1, input bit n2,
                        input bit s, input bit clr);
        bit nv  = 1'b0;
        int nd1 = 0, nd2 = 0, np = 0;
        pwm_i   = {n2, n1, ~p2, ~p1};
        sync_i  = s;
        clear_i = clr;
        h_p1[cyc % HIST] = p1;
        h_p2[cyc % HIST] = p2;
        if (s) begin
            if (last_sync >= 0) begin
                nv  = 1'b1;
                np  = cyc - last_sync;
                nd1 = count_on(1'b0, last_sync, cyc);
                nd2 = count_on(1'b1, last_sync, cyc);
            end
            last_sync = cyc;
        end else if (last_sync >= 0 && (cyc - last_sync) == MAXP) begin
            last_sync = -1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (v_pipe) begin
            exp_d1 = pv_d1;
            exp_d2 = pv_d2;
            exp_p  = pv_p;
        end
        chk("valid_o", valid_o, v_pipe);
        chk("duty_d1_o", duty_d1_o, exp_d1);
        chk("duty_d2_o", duty_d2_o, exp_d2);
        chk("period_o", period_o, exp_p);
        v_pipe = nv;
        pv_d1  = nd1;
        pv_d2  = nd2;
        pv_p   = np;
    endtask

    task automatic set_cfg(input int P, input int D1, input int D2);
        cfg_P = P; cfg_D1 = D1; cfg_D2 = D2;
        cfg_ga1 = 2; cfg_ga2 = 2; cfg_gb1 = 2; cfg_gb2 = 2;
        ov_from = -1; ov_to = -1; clr_pos = -1;
    endtask

    // Positions [from, to) of the configured period; sync at position 0
    task automatic run_range(input int from, input int to);
        for (int pos = from; pos < to; pos++) begin
            bit [1:0] a;
            bit [1:0] b;
            bit       p1;
            a  = pat(pos, cfg_P, cfg_D1, cfg_ga1, cfg_ga2);
            b  = pat(pos, cfg_P, cfg_D2, cfg_gb1, cfg_gb2);
            p1 = a[1] | (pos >= ov_from && pos <= ov_to);
            step(p1, b[1], b[0], a[0], pos == 0, pos == clr_pos);
        end
    endtask

    task automatic do_reset_mid();
        rst_i = 1'b1;
        #1;
        chk("rst duty_d1_o", duty_d1_o, 0);
        chk("rst duty_d2_o", duty_d2_o, 0);
        chk("rst period_o", period_o, 0);
        chk("rst valid_o", valid_o, 0);
        chk("rst fault_flags_o", fault_flags_o, 0);
        chk("rst trip_o", trip_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i     = 1'b0;
        last_sync = -1;
        v_pipe    = 1'b0;
        exp_d1 = 0; exp_d2 = 0; exp_p = 0;
        cyc += 2;
    endtask

    function automatic int pick_gap();
        if ($urandom_range(0, 5) == 0) return 1;
        return int'($urandom_range(2, 4));
    endfunction

    initial begin
        bit ea, eb;
        int P, d1max, d2max;
        rst_i   = 1'b1;
        pwm_i   = 4'b0011;
        sync_i  = 1'b0;
        clear_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset duty_d1_o", duty_d1_o, 0);
        chk("reset period_o", period_o, 0);
        chk("reset valid_o", valid_o, 0);
        chk("reset fault_flags_o", fault_flags_o, 0);
        chk("reset trip_o", trip_o, 0);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal 200-cycle periods
        set_cfg(200, 80, 120);
        run_range(0, 200);
        run_range(0, 200);
        chk("nominal duty_d1", duty_d1_o, 80);
        chk("nominal duty_d2", duty_d2_o, 120);
        chk("nominal period", period_o, 200);
        chk("nominal flags", fault_flags_o, 0);

        // One-cycle shoot-through on pair A
        set_cfg(200, 80, 120);
        ov_from = 150; ov_to = 150;
        run_range(0, 1);
        chk("valid at sync+1", valid_o, 0);
        run_range(1, 2);
        chk("valid at sync+2", valid_o, 1);
        run_range(2, 151);
        chk("shoot A before", fault_flags_o, 0);
        run_range(151, 152);
        chk("shoot A flag", fault_flags_o, 5'b00001);
        chk("shoot A trip early", trip_o, 0);
        run_range(152, 153);
        chk("shoot A trip", trip_o, 1);
        run_range(153, 200);
        chk("shoot A sticky", fault_flags_o, 5'b00001);

        // Clear after overlap, then 1-cycle dead-time gap on pair B
        set_cfg(200, 80, 120);
        clr_pos = 10; cfg_gb2 = 1;
        run_range(0, 11);
        chk("clear flags", fault_flags_o, 0);
        chk("clear trip lag", trip_o, 1);
        run_range(11, 12);
        chk("clear trip", trip_o, 0);
        run_range(12, 200);
        set_cfg(200, 80, 120);
        run_range(0, 1);
        chk("deadB before", fault_flags_o, 0);
        run_range(1, 2);
        chk("deadB flag", fault_flags_o, 5'b01000);
        run_range(2, 3);
        chk("deadB trip", trip_o, 1);
        clr_pos = 100;
        run_range(3, 200);
        chk("deadB cleared", fault_flags_o, 0);

        // Two-cycle gap passes; clear during a persisting overlap is overridden
        set_cfg(200, 80, 120);
        ov_from = 100; ov_to = 105; clr_pos = 103;
        run_range(0, 3);
        chk("2-gap no flag", fault_flags_o, 0);
        run_range(3, 104);
        chk("clear vs overlap", fault_flags_o, 5'b00001);
        run_range(104, 110);
        clr_pos = 110;
        run_range(110, 111);
        chk("clear after overlap", fault_flags_o, 0);
        run_range(111, 112);
        chk("trip after clear", trip_o, 0);
        run_range(112, 200);

        // Randomized periods, duties and gaps
        ea = 1'b0;
        eb = 1'b0;
        for (int k = 0; k < 20; k++) begin
            P = int'($urandom_range(40, 250));
            set_cfg(P, 1, 1);
            cfg_ga1 = pick_gap(); cfg_ga2 = pick_gap();
            cfg_gb1 = pick_gap(); cfg_gb2 = pick_gap();
            d1max = P - cfg_ga1 - cfg_ga2 - 1;
            d2max = P - cfg_gb1 - cfg_gb2 - 1;
            cfg_D1 = int'($urandom_range(1, d1max));
            cfg_D2 = int'($urandom_range(1, d2max));
            if (cfg_ga1 == 1 || cfg_ga2 == 1) ea = 1'b1;
            if (cfg_gb1 == 1 || cfg_gb2 == 1) eb = 1'b1;
            run_range(0, P);
        end
        set_cfg(200, 80, 120);
        run_range(0, 200);
        chk("random dead flags", fault_flags_o, {1'b0, eb, ea, 2'b00});

        // Sync timeout, then restart
        set_cfg(300, 80, 120);
        clr_pos = 5;
        run_range(0, 256);
        chk("timeout before", fault_flags_o, 0);
        run_range(256, 257);
        chk("timeout flag", fault_flags_o, 5'b10000);
        run_range(257, 258);
        chk("timeout trip", trip_o, 1);
        run_range(258, 300);
        set_cfg(200, 80, 120);
        run_range(0, 2);
        chk("restart first sync", valid_o, 0);
        run_range(2, 200);
        run_range(0, 2);
        chk("restart second sync", valid_o, 1);
        chk("restart period", period_o, 200);
        run_range(2, 200);

        // Reset 50 cycles into a period with flags set
        run_range(0, 50);
        do_reset_mid();
        run_range(50, 200);
        run_range(0, 2);
        chk("post-reset first sync", valid_o, 0);
        run_range(2, 200);
        run_range(0, 2);
        chk("post-reset second sync", valid_o, 1);
        chk("post-reset duty_d1", duty_d1_o, 80);
        run_range(2, 200);
        chk("post-reset flags", fault_flags_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
